// File: rtl/memory_map_pkg.sv
// Shared constants for the CPU memory-map controller: default mapache64 map,
// default wait-state table and FSM state encoding.
package memory_map_pkg;

  localparam int MM_ADDR_W      = 16;
  localparam int MM_NUM_REGIONS = 8;
  localparam int MM_WAIT_W      = 4;

  localparam int REG_RAM   = 0;
  localparam int REG_VRAM  = 1;
  localparam int REG_FW    = 2;
  localparam int REG_IO0   = 3;
  localparam int REG_IO1   = 4;
  localparam int REG_IO2   = 5;
  localparam int REG_IO3   = 6;
  localparam int REG_ROM   = 7;

  // Region 0 sits in the least significant slice.
  localparam logic [MM_NUM_REGIONS*MM_ADDR_W-1:0] DEFAULT_BASE = {
    16'h8000, 16'h7003, 16'h7002, 16'h7001,
    16'h7000, 16'h4000, 16'h3700, 16'h0000
  };

  localparam logic [MM_NUM_REGIONS*MM_ADDR_W-1:0] DEFAULT_LIMIT = {
    16'hFFFF, 16'h7003, 16'h7002, 16'h7001,
    16'h7000, 16'h6FFF, 16'h3FFF, 16'h36FF
  };

  // RAM fast, VRAM 1, firmware 5, IO regs 2 each, ROM 3.
  localparam logic [MM_NUM_REGIONS*MM_WAIT_W-1:0] DEFAULT_WAIT = {
    4'd3, 4'd2, 4'd2, 4'd2,
    4'd2, 4'd5, 4'd1, 4'd0
  };

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mm_state_e;

endpackage

// File: rtl/memory_map_ctrl_region_match.sv
// Single-region inclusive, unsigned address window comparator.
module region_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  output logic              hit
);

  assign hit = (cpu_address >= base) && (cpu_address <= limit);

endmodule

// File: rtl/memory_map_ctrl.sv
// CPU memory-map controller: base/limit decode to one-hot chip selects,
// per-region wait-state insertion via cpu_rdy, saturating miss counter.
module memory_map_ctrl
  import memory_map_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 8,
  parameter int WAIT_W      = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DEFAULT_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = DEFAULT_LIMIT,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT  = DEFAULT_WAIT,
  parameter int MISS_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      cpu_address,
  input  logic                   addr_valid,
  output logic [NUM_REGIONS-1:0] select,
  output logic                   cpu_rdy,
  output logic                   decode_miss,
  output logic [MISS_CNT_W-1:0]  miss_count,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [NUM_REGIONS-1:0] hit;
  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;
  logic [WAIT_W-1:0]      hit_wait;

  mm_state_e         state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0]  lat_idx, lat_idx_n;
  logic              miss_set;
  logic              access;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    region_match #(.ADDR_W(ADDR_W)) u_match (
      .cpu_address (cpu_address),
      .base        (REGION_BASE[i*ADDR_W +: ADDR_W]),
      .limit       (REGION_LIMIT[i*ADDR_W +: ADDR_W]),
      .hit         (hit[i])
    );
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_wait = REGION_WAIT[hit_idx*WAIT_W +: WAIT_W];

  // Gating with rst_n keeps cpu_rdy high for the whole reset pulse.
  assign access = addr_valid && rst_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lat_idx_n = lat_idx;
    select    = '0;
    cpu_rdy   = 1'b1;
    miss_set  = 1'b0;
    case (state)
      IDLE: begin
        if (hit_any) select[hit_idx] = 1'b1;
        if (access) begin
          if (!hit_any) begin
            miss_set = 1'b1;
          end else if (hit_wait != '0) begin
            cpu_rdy   = 1'b0;
            lat_idx_n = hit_idx;
            cnt_n     = hit_wait - WAIT_W'(1);
            if (hit_wait > WAIT_W'(1)) state_n = WAIT;
          end
        end
      end
      WAIT: begin
        select[lat_idx] = 1'b1;
        if (cnt != '0) begin
          cpu_rdy = 1'b0;
          cnt_n   = cnt - WAIT_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_idx     <= '0;
      decode_miss <= 1'b0;
      miss_count  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lat_idx     <= lat_idx_n;
      decode_miss <= miss_set;
      if (miss_set && (miss_count != {MISS_CNT_W{1'b1}}))
        miss_count <= miss_count + MISS_CNT_W'(1);
    end
  end

  assign busy = (state == WAIT);

endmodule

// File: tb/tb_memory_map_ctrl.sv
// Directed bench for memory_map_ctrl: default map with wait states, default map
// with zero waits, and a two-region overlapping map share one stimulus stream.
module tb_memory_map_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic        addr_valid = 1'b0;

  logic [7:0] d_select;  logic d_rdy, d_miss, d_busy;  logic [7:0] d_cnt;
  logic [7:0] z_select;  logic z_rdy, z_miss, z_busy;  logic [7:0] z_cnt;
  logic [1:0] o_select;  logic o_rdy, o_miss, o_busy;  logic [7:0] o_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_map_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_address(cpu_address), .addr_valid(addr_valid),
    .select(d_select), .cpu_rdy(d_rdy), .decode_miss(d_miss),
    .miss_count(d_cnt), .busy(d_busy)
  );

  memory_map_ctrl #(.REGION_WAIT(32'h0)) u_dec (
    .clk(clk), .rst_n(rst_n), .cpu_address(cpu_address), .addr_valid(addr_valid),
    .select(z_select), .cpu_rdy(z_rdy), .decode_miss(z_miss),
    .miss_count(z_cnt), .busy(z_busy)
  );

  memory_map_ctrl #(
    .NUM_REGIONS(2),
    .REGION_BASE({16'h0000, 16'h1000}),
    .REGION_LIMIT({16'hFFFF, 16'h1FFF}),
    .REGION_WAIT(8'h00)
  ) u_ovl (
    .clk(clk), .rst_n(rst_n), .cpu_address(cpu_address), .addr_valid(addr_valid),
    .select(o_select), .cpu_rdy(o_rdy), .decode_miss(o_miss),
    .miss_count(o_cnt), .busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, drive, then let combinational paths settle.
  task automatic step(input logic [15:0] a, input logic v);
    @(negedge clk);
    cpu_address = a;
    addr_valid  = v;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] dec_addr [5] = '{16'h0000, 16'h36FF, 16'h3700, 16'h7003, 16'hFFFF};
  logic [7:0]  dec_sel  [5] = '{8'h01, 8'h01, 8'h02, 8'h40, 8'h80};

  initial begin
    step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
    chk("rst_rdy",   d_rdy,    1);
    chk("rst_busy",  d_busy,   0);
    chk("rst_miss",  d_miss,   0);
    chk("rst_cnt",   d_cnt,    0);
    chk("rst_sel",   d_select, 8'h01);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(dec_addr[i], 1'b1);
      chk($sformatf("dec_sel_%0d", i), z_select, dec_sel[i]);
      chk($sformatf("dec_rdy_%0d", i), z_rdy, 1);
    end
    step(16'h0000, 1'b0);
    chk("dec_nomiss", z_miss, 0);
    repeat (4) step(16'h0000, 1'b0);
    chk("dec_cnt", z_cnt, 0);
    chk("dut_idle", d_busy, 0);

    step(16'h8000, 1'b1);
    chk("rom_rdy0", d_rdy, 0); chk("rom_sel0", d_select, 8'h80); chk("rom_busy0", d_busy, 0);
    step(16'h0000, 1'b0);
    chk("rom_rdy1", d_rdy, 0); chk("rom_sel1", d_select, 8'h80); chk("rom_busy1", d_busy, 1);
    step(16'h0000, 1'b0);
    chk("rom_rdy2", d_rdy, 0); chk("rom_sel2", d_select, 8'h80);
    step(16'h0000, 1'b0);
    chk("rom_rdy3", d_rdy, 1); chk("rom_sel3", d_select, 8'h80); chk("rom_busy3", d_busy, 1);
    step(16'h0000, 1'b0);
    chk("rom_done_busy", d_busy, 0); chk("rom_done_sel", d_select, 8'h01);

    step(16'h7FFF, 1'b1);
    chk("miss_sel", d_select, 0); chk("miss_rdy", d_rdy, 1); chk("miss_pre", d_miss, 0);
    step(16'h0000, 1'b0);
    chk("miss_pulse", d_miss, 1); chk("miss_cnt1", d_cnt, 1);
    step(16'h0000, 1'b0);
    chk("miss_end", d_miss, 0);

    step(16'h7004, 1'b1);
    step(16'h7FFF, 1'b1);
    chk("b2b_p1", d_miss, 1);
    step(16'h0000, 1'b0);
    chk("b2b_p2", d_miss, 1); chk("b2b_cnt", d_cnt, 3);
    step(16'h0000, 1'b0);
    chk("b2b_end", d_miss, 0);

    for (int i = 0; i < 300; i++) step(16'h7500, 1'b1);
    step(16'h0000, 1'b0);
    chk("sat_cnt", d_cnt, 8'hFF);
    chk("sat_cnt_z", z_cnt, 8'hFF);

    step(16'h1800, 1'b1);
    chk("ovl_sel_lo", o_select, 2'b01);
    step(16'h2000, 1'b1);
    chk("ovl_sel_hi", o_select, 2'b10);
    step(16'h0000, 1'b0);

    step(16'h4000, 1'b1);
    chk("rst_stall1", d_rdy, 0);
    step(16'h4000, 1'b0);
    chk("rst_stall2_busy", d_busy, 1); chk("rst_stall2_rdy", d_rdy, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_abort_rdy", d_rdy, 1); chk("rst_abort_busy", d_busy, 0);
    step(16'h4000, 1'b0);
    rst_n = 1'b1;
    step(16'h4000, 1'b0);
    chk("rel_busy", d_busy, 0); chk("rel_cnt", d_cnt, 0); chk("rel_rdy", d_rdy, 1);

    step(16'h3700, 1'b1);
    chk("w1_a", d_rdy, 0);
    step(16'h3700, 1'b0);
    chk("w1_b", d_rdy, 1); chk("w1_busy", d_busy, 0);
    step(16'h3700, 1'b1);
    chk("w1_c", d_rdy, 0);
    step(16'h3700, 1'b0);
    chk("w1_d", d_rdy, 1);

    chk("z_busy", z_busy, 0);
    chk("o_rdy", o_rdy, 1);
    chk("o_miss", o_miss, 0);
    chk("o_cnt", o_cnt, 0);
    chk("o_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
